painel_interruptores: RTL and testbench
=======================================

// Module: painel_interruptores
// PURPOSE
//  Front end that produces the packed inputs of the 16-zone priority lamp selector.
//  Conditions raw panel signals: 16 push buttons, 16 presence sensors and 1 master key.
//  Outputs: packed 2-bit commands int_o[31:0], sensor flags s_o[15:0] and master m_o.
//  Sits between the board I/O pins and the selector.
// PARAMETERS
//  N_PAINEL    16  number of zones; int_o is 2*N_PAINEL bits wide
//  DEB_CYCLES  4   consecutive stable samples required to accept a button or master-key change (>=1)
//  HOLD_CYCLES 8   cycles that s_o[i] stays high after its sensor drops (>=0)
// PORTS
//  clk        in   1        single system clock, rising edge
//  rst_n      in   1        asynchronous reset, active low
//  btn_raw    in   16       raw push buttons, async, bouncing; bit i = zone i
//  pres_raw   in   16       raw presence sensors, async; bit i = zone i
//  m_raw      in   1        raw master key, async
//  all_off    in   1        synchronous clear of every command, clk domain
//  int_o      out  32       packed commands; int_o[2i+1:2i] = zone i
//  s_o        out  16       conditioned presence flags
//  m_o        out  1        debounced master key
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - Synchronizers, debounce counters and hold counters are cleared.
//   - int_o = 0 (all OFF), s_o = 0, m_o = 0, accepted button levels = 0.
//  Synchronization:
//   - Every raw input passes a 2-FF synchronizer before any other use.
//  Debounce (per button and for the master key):
//   - Counter advances on each edge at which the synced value differs from the accepted value.
//   - The counter clears on any edge at which they are equal.
//   - The accepted value flips on the DEB_CYCLES-th consecutive differing edge; the counter clears at the same edge.
//  Master key:
//   - m_o = accepted level.
//   - Raw change settled before edge 1 -> m_o changes at edge 2+DEB_CYCLES.
//  Command FSM (per zone):
//   - Encodings: OFF=2'b00, LOW=2'b01, HIGH=2'b10.
//   - Press event = accepted level 0->1.
//   - On a press: OFF->LOW, LOW->HIGH, HIGH->OFF; the new state appears one edge after the accepted flip.
//   - Raw press settled before edge 1 -> int_o changes at edge 3+DEB_CYCLES.
//   - 2'b11 is never produced. If it is ever held, the next edge forces OFF.
//   - Release (1->0) has no effect on the command.
//  all_off:
//   - Sampled high -> every zone = OFF at the next edge.
//   - all_off overrides a press event on the same edge.
//   - That press is consumed, not deferred.
//  Presence hold (per zone):
//   - Synced sensor = 1 -> s_o[i] <= 1 and hold counter <= HOLD_CYCLES.
//   - Synced sensor = 0 and counter != 0 -> counter decrements and s_o[i] stays 1.
//   - Synced sensor = 0 and counter == 0 -> s_o[i] <= 0.
//   - Raw rise before edge 1 -> s_o[i]=1 at edge 3.
//   - Raw fall before edge 1 -> s_o[i]=0 at edge 3+HOLD_CYCLES.
//   - A re-rise during the hold reloads the counter.
//  Zone independence:
//   - Zones are fully independent; simultaneous presses in several zones all take effect on the same edge.
//  Reset mid-operation:
//   - Reset during debounce or hold aborts it immediately.
//   - Partially counted changes are lost; all outputs are 0 until the first post-reset event.
//  Output timing:
//   - All outputs are registered; there are no combinational paths from inputs to outputs.
// STRUCTURE
//  Package painel_pkg:
//   - CMD_OFF, CMD_LOW, CMD_HIGH localparams and the cmd_t 2-bit type.
//   - Width helper for the counters: $clog2 of the max of DEB_CYCLES and HOLD_CYCLES, plus 1.
//  Sub-module painel_canal:
//   - One zone: synchronizers, debounce, command FSM and presence hold.
//   - Instantiated N_PAINEL times by a generate loop.
//   - Its int and s outputs are packed in the top module.
//  Master-key path:
//   - Synchronizer plus debounce only, in the top module.
//   - The master key reuses the debounce logic from painel_canal or a shared debounce function.
// TESTING
//  1 Reset values: rst_n=0, random raw inputs -> int_o=0, s_o=0, m_o=0 throughout; release reset, all raw inputs 0 -> outputs stay 0.
//  2 Clean press: btn_raw[3] 0->1 with DEB=4 -> int_o[7:6]=01 at edge 7, all other bits 0; three more clean presses -> 10, 00, 01.
//  3 Bounce: btn_raw[0] toggles every 2 cycles for 20 cycles, then holds high -> exactly one press and int_o[1:0]=01; glitches shorter than DEB have no effect.
//  4 Presence hold: pres_raw[15] high 5 cycles, then low, HOLD=8 -> s_o[15] rises at edge 3 and falls 11 edges after the raw fall; a re-pulse during the hold extends it.
//  5 all_off collision: zones 2 and 9 at HIGH, press event on zone 2 coincides with all_off=1 -> int_o=0 next edge, and no later LOW appears on zone 2.
//  6 Mid-operation reset: rst_n pulsed low while zone 5 is mid-debounce and s_o[1] is in hold -> all outputs 0 immediately, with no spurious press after release.

Source files
------------

// File: rtl/painel_pkg.sv
// Shared types, command encodings and helpers for the lamp-panel front end.
//   cmd_t        2-bit per-zone command (OFF/LOW/HIGH; 2'b11 is illegal)
//   deb_act_t    per-edge debounce decision
//   cnt_width()  width of the debounce/hold counters
//   deb_action() debounce step shared by the zone buttons and the master key
//   cmd_next()   command advanced by one press
package painel_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_OFF  = 2'b00;
  localparam cmd_t CMD_LOW  = 2'b01;
  localparam cmd_t CMD_HIGH = 2'b10;

  typedef enum logic [1:0] {
    DebClear,
    DebCount,
    DebFlip
  } deb_act_t;

  // Wide enough to hold max(deb, hold) itself, not just max-1.
  function automatic int unsigned cnt_width(int unsigned deb, int unsigned hold);
    int unsigned m;
    m = (deb > hold) ? deb : hold;
    return $clog2(m) + 1;
  endfunction

  // at_limit: the counter already holds DEB_CYCLES-1, so this differing edge
  // is the DEB_CYCLES-th in a row and the accepted level flips.
  function automatic deb_act_t deb_action(logic sync, logic acc, logic at_limit);
    if (sync == acc) begin
      return DebClear;
    end else if (at_limit) begin
      return DebFlip;
    end else begin
      return DebCount;
    end
  endfunction

  function automatic cmd_t cmd_next(cmd_t cur);
    cmd_t nxt;
    case (cur)
      CMD_OFF: nxt = CMD_LOW;
      CMD_LOW: nxt = CMD_HIGH;
      default: nxt = CMD_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/painel_canal.sv
// One panel zone: synchronizes its button and presence sensor, debounces the
// button, runs the OFF->LOW->HIGH->OFF command cycle on each accepted press and
// stretches the presence flag for HOLD_CYCLES after the sensor drops.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   btn_i       raw push button (asynchronous, bouncing)
//   pres_i      raw presence sensor (asynchronous)
//   all_off_i   synchronous clear of the command (clk domain)
//   cmd_o       registered command: 00 OFF, 01 LOW, 10 HIGH
//   s_o         registered, hold-stretched presence flag
module painel_canal
  import painel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  input  logic       pres_i,
  input  logic       all_off_i,
  output logic [1:0] cmd_o,
  output logic       s_o
);

  localparam int unsigned      CNT_W     = cnt_width(DEB_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             btn_meta_q, btn_sync_q;
  logic             pres_meta_q, pres_sync_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             acc_q, acc_d;
  logic             acc_prev_q;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             s_q, s_d;
  logic             press;
  deb_act_t         deb_act;

  // Two-flop synchronizers for both raw inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      pres_meta_q <= 1'b0;
      pres_sync_q <= 1'b0;
    end else begin
      btn_meta_q  <= btn_i;
      btn_sync_q  <= btn_meta_q;
      pres_meta_q <= pres_i;
      pres_sync_q <= pres_meta_q;
    end
  end

  always_comb begin
    acc_d     = acc_q;
    deb_cnt_d = '0;
    deb_act   = deb_action(btn_sync_q, acc_q, deb_cnt_q == DEB_LIMIT);
    unique case (deb_act)
      DebCount: deb_cnt_d = deb_cnt_q + CNT_ONE;
      DebFlip:  acc_d     = ~acc_q;
      default:  deb_cnt_d = '0;
    endcase
  end

  // Press is a one-cycle pulse, so an all_off on that edge consumes it.
  assign press = acc_q & ~acc_prev_q;

  always_comb begin
    cmd_d = cmd_q;
    if (all_off_i) begin
      cmd_d = CMD_OFF;
    end else if (cmd_q == 2'b11) begin
      cmd_d = CMD_OFF;
    end else if (press) begin
      cmd_d = cmd_next(cmd_q);
    end
  end

  always_comb begin
    hold_cnt_d = '0;
    s_d        = 1'b0;
    if (pres_sync_q) begin
      hold_cnt_d = HOLD_LOAD;
      s_d        = 1'b1;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - CNT_ONE;
      s_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q  <= '0;
      acc_q      <= 1'b0;
      acc_prev_q <= 1'b0;
      cmd_q      <= CMD_OFF;
      hold_cnt_q <= '0;
      s_q        <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      acc_q      <= acc_d;
      acc_prev_q <= acc_q;
      cmd_q      <= cmd_d;
      hold_cnt_q <= hold_cnt_d;
      s_q        <= s_d;
    end
  end

  assign cmd_o = cmd_q;
  assign s_o   = s_q;

endmodule

// File: rtl/painel_interruptores.sv
// Panel front end feeding the 16-zone priority lamp selector. Conditions the
// raw board signals into registered, packed selector inputs.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   btn_raw     raw push buttons, bit i = zone i
//   pres_raw    raw presence sensors, bit i = zone i
//   m_raw       raw master key
//   all_off     synchronous clear of every command
//   int_o       packed commands, int_o[2i+1:2i] = zone i
//   s_o         hold-stretched presence flags
//   m_o         debounced master key
module painel_interruptores
  import painel_pkg::*;
#(
  parameter int unsigned N_PAINEL    = 16,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_PAINEL-1:0]   btn_raw,
  input  logic [N_PAINEL-1:0]   pres_raw,
  input  logic                  m_raw,
  input  logic                  all_off,
  output logic [2*N_PAINEL-1:0] int_o,
  output logic [N_PAINEL-1:0]   s_o,
  output logic                  m_o
);

  localparam int unsigned      CNT_W     = cnt_width(DEB_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  for (genvar i = 0; i < N_PAINEL; i++) begin : g_zone
    painel_canal #(
      .DEB_CYCLES (DEB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_canal (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_i    (btn_raw[i]),
      .pres_i   (pres_raw[i]),
      .all_off_i(all_off),
      .cmd_o    (int_o[2*i+1:2*i]),
      .s_o      (s_o[i])
    );
  end

  // Master key: synchronizer and debounce only.
  logic             m_meta_q, m_sync_q;
  logic             m_acc_q, m_acc_d;
  logic [CNT_W-1:0] m_cnt_q, m_cnt_d;
  deb_act_t         m_act;

  always_comb begin
    m_acc_d = m_acc_q;
    m_cnt_d = '0;
    m_act   = deb_action(m_sync_q, m_acc_q, m_cnt_q == DEB_LIMIT);
    unique case (m_act)
      DebCount: m_cnt_d = m_cnt_q + CNT_ONE;
      DebFlip:  m_acc_d = ~m_acc_q;
      default:  m_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_meta_q <= 1'b0;
      m_sync_q <= 1'b0;
      m_acc_q  <= 1'b0;
      m_cnt_q  <= '0;
    end else begin
      m_meta_q <= m_raw;
      m_sync_q <= m_meta_q;
      m_acc_q  <= m_acc_d;
      m_cnt_q  <= m_cnt_d;
    end
  end

  assign m_o = m_acc_q;

endmodule

// File: tb/tb_painel_interruptores.sv
// Bench for painel_interruptores: directed scenarios plus random stimulus,
// each cycle compared against a window-based behavioural model.
module tb_painel_interruptores;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] btn_raw = '0;
  logic [15:0] pres_raw = '0;
  logic        m_raw = 1'b0;
  logic        all_off = 1'b0;
  logic [31:0] int_o;
  logic [15:0] s_o;
  logic        m_o;

  int tests_run = 0;
  int tests_failed = 0;

  painel_interruptores dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .pres_raw(pres_raw),
    .m_raw   (m_raw),
    .all_off (all_off),
    .int_o   (int_o),
    .s_o     (s_o),
    .m_o     (m_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A raw value sampled at edge k is seen by the logic at edge k+2. A level is
  // accepted when the last DEB seen samples all differ from the accepted one;
  // a presence flag is high while any of the last HOLD+1 seen samples is high.
  typedef struct packed {
    logic [15:0] btn;
    logic [15:0] pres;
    logic        m;
  } samp_t;

  samp_t       raw_q[$];
  samp_t       y_q[$];
  logic [15:0] acc_b;
  logic        acc_m;
  logic [15:0] pend;
  int          cmd_m[16];
  logic [31:0] exp_int;
  logic [15:0] exp_s;
  logic        exp_m;

  function automatic logic win_btn(int i, logic accv);
    for (int j = 0; j < DEB; j++) begin
      int   idx;
      logic v;
      idx = y_q.size() - 1 - j;
      v = (idx >= 0) ? y_q[idx].btn[i] : 1'b0;
      if (v == accv) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic win_m(logic accv);
    for (int j = 0; j < DEB; j++) begin
      int   idx;
      logic v;
      idx = y_q.size() - 1 - j;
      v = (idx >= 0) ? y_q[idx].m : 1'b0;
      if (v == accv) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic win_pres(int i);
    for (int j = 0; j <= HOLD; j++) begin
      int idx;
      idx = y_q.size() - 1 - j;
      if (idx >= 0 && y_q[idx].pres[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    samp_t z;
    z = '0;
    raw_q.delete();
    y_q.delete();
    raw_q.push_back(z);
    raw_q.push_back(z);
    acc_b = '0;
    acc_m = 1'b0;
    pend = '0;
    for (int i = 0; i < 16; i++) cmd_m[i] = 0;
    exp_int = '0;
    exp_s = '0;
    exp_m = 1'b0;
  endtask

  task automatic model_step();
    samp_t       r;
    logic [15:0] new_pend;
    r.btn = btn_raw;
    r.pres = pres_raw;
    r.m = m_raw;
    raw_q.push_back(r);
    y_q.push_back(raw_q[raw_q.size() - 3]);
    while (raw_q.size() > 3) void'(raw_q.pop_front());
    while (y_q.size() > 32) void'(y_q.pop_front());
    for (int i = 0; i < 16; i++) begin
      if (all_off) cmd_m[i] = 0;
      else if (pend[i]) cmd_m[i] = (cmd_m[i] + 1) % 3;
    end
    new_pend = '0;
    for (int i = 0; i < 16; i++) begin
      if (win_btn(i, acc_b[i])) begin
        acc_b[i] = ~acc_b[i];
        new_pend[i] = acc_b[i];
      end
    end
    pend = new_pend;
    if (win_m(acc_m)) acc_m = ~acc_m;
    for (int i = 0; i < 16; i++) begin
      exp_s[i] = win_pres(i);
      exp_int[2*i +: 2] = 2'(cmd_m[i]);
    end
    exp_m = acc_m;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      btn_raw = 16'($urandom);
      pres_raw = 16'($urandom);
      m_raw = 1'($urandom);
      cyc();
      tests_run++;
      if ({int_o, s_o, m_o} !== 49'd0) begin
        tests_failed++;
        $display("FAIL reset_hold: int_o=%h s_o=%h m_o=%b, required all 0", int_o, s_o, m_o);
      end
    end
    btn_raw = '0;
    pres_raw = '0;
    m_raw = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      tests_run++;
      if ({int_o, s_o, m_o} !== 49'd0) begin
        tests_failed++;
        $display("FAIL reset_release: int_o=%h s_o=%h m_o=%b, required all 0", int_o, s_o,
                 m_o);
      end
    end
  endtask

  task automatic test_master();
    for (int ph = 0; ph < 2; ph++) begin
      m_raw = (ph == 0);
      for (int k = 1; k <= 9; k++) begin
        cyc();
        tests_run++;
        if ({int_o, s_o, m_o} !== {exp_int, exp_s, exp_m}) begin
          tests_failed++;
          $display("FAIL master_model: int_o=%h s_o=%h m_o=%b, required %h %h %b", int_o, s_o,
                   m_o, exp_int, exp_s, exp_m);
        end
        if (k == 5 || k == 6) begin
          logic want;
          want = (k == 6) ? (ph == 0) : (ph != 0);
          tests_run++;
          if (m_o !== want) begin
            tests_failed++;
            $display("FAIL master_edge%0d: m_o=%b, required %b", k, m_o, want);
          end
        end
      end
    end
  endtask

  task automatic test_clean_press();
    logic [1:0] want_seq[4];
    logic [1:0] prev;
    want_seq = '{2'b01, 2'b10, 2'b00, 2'b01};
    prev = 2'b00;
    for (int p = 0; p < 4; p++) begin
      btn_raw[3] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        cyc();
        tests_run++;
        if ({int_o, s_o, m_o} !== {exp_int, exp_s, exp_m}) begin
          tests_failed++;
          $display("FAIL press_model: int_o=%h s_o=%h m_o=%b, required %h %h %b", int_o, s_o,
                   m_o, exp_int, exp_s, exp_m);
        end
        if (k == 6) begin
          tests_run++;
          if (int_o !== {24'd0, prev, 6'd0}) begin
            tests_failed++;
            $display("FAIL press%0d_edge6: int_o=%h, required zone3=%b only", p, int_o, prev);
          end
        end
        if (k == 7) begin
          tests_run++;
          if (int_o !== {24'd0, want_seq[p], 6'd0}) begin
            tests_failed++;
            $display("FAIL press%0d_edge7: int_o=%h, required zone3=%b only", p, int_o,
                     want_seq[p]);
          end
        end
      end
      prev = want_seq[p];
      btn_raw[3] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        cyc();
        tests_run++;
        if (int_o[7:6] !== prev) begin
          tests_failed++;
          $display("FAIL release%0d: int_o[7:6]=%b, required %b", p, int_o[7:6], prev);
        end
      end
    end
  endtask

  task automatic test_bounce();
    all_off = 1'b1;
    cyc();
    all_off = 1'b0;
    for (int c = 0; c < 20; c++) begin
      btn_raw[0] = ((c / 2) % 2) == 0;
      cyc();
      tests_run++;
      if (int_o[1:0] !== 2'b00 || int_o !== exp_int) begin
        tests_failed++;
        $display("FAIL bounce_glitch: int_o=%h, required zone0=00 model=%h", int_o, exp_int);
      end
    end
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      tests_run++;
      if (int_o !== exp_int) begin
        tests_failed++;
        $display("FAIL bounce_model: int_o=%h, required %h", int_o, exp_int);
      end
    end
    tests_run++;
    if (int_o[1:0] !== 2'b01) begin
      tests_failed++;
      $display("FAIL bounce_single_press: int_o[1:0]=%b, required 01", int_o[1:0]);
    end
    btn_raw[0] = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic test_presence();
    for (int k = 1; k <= 20; k++) begin
      pres_raw[15] = (k <= 5);
      cyc();
      tests_run++;
      if (s_o !== exp_s) begin
        tests_failed++;
        $display("FAIL pres_model: s_o=%h, required %h", s_o, exp_s);
      end
      if (k == 2 || k == 3 || k == 15 || k == 16) begin
        logic want;
        want = (k == 3 || k == 15);
        tests_run++;
        if (s_o[15] !== want) begin
          tests_failed++;
          $display("FAIL pres_edge%0d: s_o[15]=%b, required %b", k, s_o[15], want);
        end
      end
    end
    for (int k = 1; k <= 24; k++) begin
      pres_raw[15] = (k <= 3 || k == 9);
      cyc();
      tests_run++;
      if (s_o !== exp_s) begin
        tests_failed++;
        $display("FAIL repulse_model: s_o=%h, required %h", s_o, exp_s);
      end
      if (k == 14 || k == 19 || k == 20) begin
        logic want;
        want = (k != 20);
        tests_run++;
        if (s_o[15] !== want) begin
          tests_failed++;
          $display("FAIL repulse_edge%0d: s_o[15]=%b, required %b", k, s_o[15], want);
        end
      end
    end
    pres_raw[15] = 1'b0;
  endtask

  task automatic test_all_off_collision();
    for (int p = 0; p < 2; p++) begin
      btn_raw[2] = 1'b1;
      btn_raw[9] = 1'b1;
      repeat (10) cyc();
      btn_raw[2] = 1'b0;
      btn_raw[9] = 1'b0;
      repeat (8) cyc();
    end
    tests_run++;
    if (int_o[5:4] !== 2'b10 || int_o[19:18] !== 2'b10 || int_o !== exp_int) begin
      tests_failed++;
      $display("FAIL both_high: int_o=%h, required zones 2,9=10 model=%h", int_o, exp_int);
    end
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      all_off = (k == 7);
      cyc();
      if (k == 6) begin
        tests_run++;
        if (int_o[5:4] !== 2'b10) begin
          tests_failed++;
          $display("FAIL collide_edge6: int_o[5:4]=%b, required 10", int_o[5:4]);
        end
      end
    end
    all_off = 1'b0;
    tests_run++;
    if (int_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL collide_clear: int_o=%h, required 0", int_o);
    end
    for (int k = 0; k < 12; k++) begin
      cyc();
      tests_run++;
      if (int_o !== 32'd0 || int_o !== exp_int) begin
        tests_failed++;
        $display("FAIL collide_consumed: int_o=%h, required 0 model=%h", int_o, exp_int);
      end
    end
    btn_raw[2] = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic test_midreset();
    btn_raw[5] = 1'b1;
    m_raw = 1'b1;
    repeat (10) cyc();
    btn_raw[5] = 1'b0;
    repeat (8) cyc();
    pres_raw[1] = 1'b1;
    repeat (3) cyc();
    pres_raw[1] = 1'b0;
    btn_raw[5] = 1'b1;
    repeat (3) cyc();
    tests_run++;
    if (s_o[1] !== 1'b1 || int_o[11:10] !== 2'b01 || m_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: s_o[1]=%b int_o[11:10]=%b m_o=%b, required 1 01 1", s_o[1],
               int_o[11:10], m_o);
    end
    #2;
    rst_n = 1'b0;
    btn_raw = '0;
    pres_raw = '0;
    m_raw = 1'b0;
    #1;
    tests_run++;
    if ({int_o, s_o, m_o} !== 49'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: int_o=%h s_o=%h m_o=%b, required all 0", int_o, s_o, m_o);
    end
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      tests_run++;
      if ({int_o, s_o, m_o} !== 49'd0 || {int_o, s_o, m_o} !== {exp_int, exp_s, exp_m}) begin
        tests_failed++;
        $display("FAIL midreset_after: int_o=%h s_o=%h m_o=%b, required all 0", int_o, s_o,
                 m_o);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      btn_raw = btn_raw ^ 16'($urandom & $urandom & $urandom);
      pres_raw = pres_raw ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) m_raw = ~m_raw;
      all_off = ($urandom_range(0, 40) == 0);
      cyc();
      tests_run++;
      if ({int_o, s_o, m_o} !== {exp_int, exp_s, exp_m}) begin
        tests_failed++;
        $display("FAIL random_c%0d: int_o=%h s_o=%h m_o=%b, required %h %h %b", c, int_o, s_o,
                 m_o, exp_int, exp_s, exp_m);
      end
    end
    all_off = 1'b0;
  endtask

  initial begin
    test_reset();
    test_master();
    test_clean_press();
    test_bounce();
    test_presence();
    test_all_off_collision();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
